// File: rtl/debug_slave_pkg.sv
// Shared defaults, a constant-evaluable clog2 and the command record for the
// JTAG debug-slave command synchronizer.
package debug_slave_pkg;

  localparam int DEF_SR_W        = 38;
  localparam int DEF_IR_W        = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEPTH       = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Command record at the default widths, as seen by a consumer of the queue.
  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/debug_slave_sync.sv
// Brings one tck-domain strobe level into clk and emits a registered
// single-cycle pulse per rising edge.
module debug_slave_sync
  import debug_slave_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] chain_r;
  logic [STAGES-1:0] flushed_r;
  logic              hist_r;
  logic              armed_r;
  logic              rise_r;

  // Synchronizer chain, flush tracking, arming and edge detect. Arming only
  // trusts a low once real samples have replaced the reset zeros in the chain,
  // so a strobe held high across reset cannot masquerade as a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_r   <= '0;
      flushed_r <= '0;
      hist_r    <= 1'b0;
      armed_r   <= 1'b0;
      rise_r    <= 1'b0;
    end else begin
      chain_r   <= {chain_r[STAGES-2:0], async_in};
      flushed_r <= {flushed_r[STAGES-2:0], 1'b1};
      hist_r    <= chain_r[STAGES-1];
      armed_r   <= armed_r | (flushed_r[STAGES-1] & ~chain_r[STAGES-1]);
      rise_r    <= armed_r & chain_r[STAGES-1] & ~hist_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/debug_slave_cmd_sync.sv
// Moves virtual-JTAG update-DR commands {ir_in, sr} into the clk domain via a
// small first-word-fall-through queue; update-IR becomes a one-cycle pulse.
module debug_slave_cmd_sync
  import debug_slave_pkg::*;
#(
  parameter int SR_W        = DEF_SR_W,
  parameter int IR_W        = DEF_IR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [SR_W-1:0]        sr,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [IR_W-1:0]        cmd_ir,
  output logic [SR_W-1:0]        cmd_data,
  output logic [(2**IR_W)-1:0]   cmd_hit,
  output logic                   uir_pulse,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int NH = 2 ** IR_W;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic            udr_evt_s;
  logic            uir_evt_s;
  logic [IR_W-1:0] mem_ir_r   [DEPTH];
  logic [SR_W-1:0] mem_data_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_nxt_s;
  logic [PW-1:0]   rd_nxt_s;
  logic            full_s;
  logic            pop_s;
  logic            push_ok_s;
  logic            drop_s;
  logic            valid_nxt_s;
  logic [IR_W-1:0] head_ir_nxt_s;
  logic [NH-1:0]   hit_nxt_s;
  logic            cmd_valid_r;
  logic [NH-1:0]   cmd_hit_r;
  logic            overflow_r;
  logic [PW-1:0]   level_r;

  debug_slave_sync #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_udr),
    .rise     (udr_evt_s)
  );

  debug_slave_sync #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_uir),
    .rise     (uir_evt_s)
  );

  // Queue control and next-state of the registered head view.
  always_comb begin
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s       = cmd_valid_r & cmd_ready;
    push_ok_s   = udr_evt_s & (~full_s | pop_s);
    drop_s      = udr_evt_s & full_s & ~pop_s;
    wr_nxt_s    = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    rd_nxt_s    = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    valid_nxt_s = (wr_nxt_s != rd_nxt_s);
    // The entry being written this edge becomes the head when it lands in the next read slot.
    if (push_ok_s && (wr_ptr_r[AW-1:0] == rd_nxt_s[AW-1:0])) begin
      head_ir_nxt_s = ir_in;
    end else begin
      head_ir_nxt_s = mem_ir_r[rd_nxt_s[AW-1:0]];
    end
    hit_nxt_s = '0;
    for (int i = 0; i < NH; i++) begin
      hit_nxt_s[i] = valid_nxt_s && (head_ir_nxt_s == IR_W'(i));
    end
  end

  // Command storage; contents are meaningless while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_ir_r[wr_ptr_r[AW-1:0]]   <= ir_in;
      mem_data_r[wr_ptr_r[AW-1:0]] <= sr;
    end
  end

  // Pointers, status flags and the registered head decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      cmd_valid_r <= 1'b0;
      cmd_hit_r   <= '0;
      overflow_r  <= 1'b0;
      level_r     <= '0;
    end else begin
      wr_ptr_r    <= wr_nxt_s;
      rd_ptr_r    <= rd_nxt_s;
      cmd_valid_r <= valid_nxt_s;
      cmd_hit_r   <= hit_nxt_s;
      overflow_r  <= drop_s ? 1'b1 : (overflow_clr ? 1'b0 : overflow_r);
      level_r     <= wr_nxt_s - rd_nxt_s;
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign cmd_ir    = mem_ir_r[rd_ptr_r[AW-1:0]];
  assign cmd_data  = mem_data_r[rd_ptr_r[AW-1:0]];
  assign cmd_hit   = cmd_hit_r;
  assign uir_pulse = uir_evt_s;
  assign overflow  = overflow_r;
  assign level     = level_r;

endmodule

// File: doc/debug_slave_cmd_sync.md
DEBUG_SLAVE_CMD_SYNC -- requirements
Module: debug_slave_cmd_sync

Interface
REQ-001 Parameter SR_W, default 38: width of the JTAG data shift register sr and of cmd_data.
REQ-002 Parameter IR_W, default 2: width of the virtual-JTAG instruction and of cmd_ir.
REQ-003 Parameter SYNC_STAGES, default 2, minimum 2: synchronizer flops per tck-domain strobe.
REQ-004 Parameter DEPTH, default 4, power of two and at least 2: number of command queue entries.
REQ-005 clk  in  1: system clock; the only clock of the block.
REQ-006 reset  in  1: asynchronous, active-high reset.
REQ-007 ir_in  in  IR_W: tck-domain instruction, quasi-static while vs_udr is high.
REQ-008 sr  in  SR_W: tck-domain shift-register contents, quasi-static while vs_udr is high.
REQ-009 vs_udr  in  1: tck-domain update-DR level.
REQ-010 vs_uir  in  1: tck-domain update-IR level.
REQ-011 cmd_valid  out  1: queue head valid.
REQ-012 cmd_ready  in  1: consumer accepts the head.
REQ-013 cmd_ir  out  IR_W: queue head instruction.
REQ-014 cmd_data  out  SR_W: queue head data; this replaces jdo.
REQ-015 cmd_hit  out  2**IR_W: one-hot decode of cmd_ir, gated by cmd_valid.
REQ-016 uir_pulse  out  1: single-cycle update-IR event.
REQ-017 overflow  out  1: sticky flag set when a command is dropped.
REQ-018 overflow_clr  in  1: clears overflow.
REQ-019 level  out  $clog2(DEPTH)+1: current queue occupancy.

Function
REQ-020 vs_udr and vs_uir shall each pass through a SYNC_STAGES-flop chain followed by one history flop, producing a rising-edge event.
REQ-021 A vs_udr edge event shall be generated only when the block is armed; armed sets once the synchronized vs_udr has been observed low after reset.
REQ-022 Latency: vs_udr first sampled high at clk edge k shall make the event true during cycle k+SYNC_STAGES.
REQ-023 On the vs_udr event, {ir_in, sr} shall be written into the queue at edge k+SYNC_STAGES+1.
REQ-024 cmd_valid shall be high in the cycle after that edge.
REQ-025 ir_in and sr shall be sampled directly at the write edge; their stability is guaranteed by the JTAG protocol for at least SYNC_STAGES+2 clk cycles.
REQ-026 The queue shall be first-word-fall-through; a pop occurs on any cycle where cmd_valid and cmd_ready are both high.
REQ-027 Push when full without a simultaneous pop: the new entry shall be dropped, overflow set, and level shall stay at DEPTH.
REQ-028 Push when full with a simultaneous pop: both shall succeed and level shall stay at DEPTH.
REQ-029 Push when empty: cmd_valid shall rise the next cycle; there is no same-cycle bypass.
REQ-030 Read and write pointers shall be $clog2(DEPTH)+1 bits wide, wrap modulo 2*DEPTH, and full/empty shall be derived from the MSB comparison.
REQ-031 overflow_clr and an overflow set in the same cycle: set wins.
REQ-032 cmd_hit shall be all zeros when cmd_valid is low.
REQ-033 uir_pulse shall be high for exactly one cycle per synchronized vs_uir rising edge, shall not be queued, and shall be subject to the same arming rule.
REQ-034 cmd_data and cmd_ir shall hold stable while cmd_valid is high and cmd_ready is low.

Reset
REQ-035 Reset shall clear: synchronizer and history flops to 0, armed to 0, both pointers to 0, overflow to 0, cmd_valid to 0, cmd_hit to 0, uir_pulse to 0, level to 0.
REQ-036 Queue storage shall not be reset; cmd_data and cmd_ir are don't-care while cmd_valid is low.
REQ-037 Reset asserted mid-operation shall discard all queued entries and any in-flight strobe.
REQ-038 vs_udr held high across reset release shall produce no push until it has gone low and then high again.

Structure
REQ-039 Package debug_slave_pkg shall hold the default parameter values, a clog2 helper, and the cmd_t struct {ir, data}.
REQ-040 One sub-module, debug_slave_sync (bit synchronizer, arming logic and rising-edge detect), shall be instantiated twice, once per strobe.
REQ-041 The queue shall be inline register-array storage; no RAM macro shall be used.

Verification
REQ-042 Single command: ir_in=2, sr=38'h15_A5A5_A5A5, vs_udr pulsed high for 6 clk -> cmd_valid rises at edge k+3, cmd_hit=4'b0100, cmd_data matches, level=1.
REQ-043 Five updates with cmd_ready=0 and DEPTH=4 -> level=4, overflow=1, head is the first command; then drain in order with 4 pops and no 5th entry present.
REQ-044 Queue full plus a push with cmd_ready=1 in the same cycle -> level stays 4, no overflow, FIFO order preserved.
REQ-045 vs_udr high during reset and across release -> no cmd_valid; a later low-then-high on vs_udr -> exactly one push.
REQ-046 vs_uir toggled 3 times, each level held 5 clk -> exactly 3 uir_pulse cycles and no queue activity; overflow_clr with a simultaneous overflow set -> overflow stays 1.
